// File: rtl/rtc_bus_sequencer_if.sv
// rtc_bus_sequencer_if: request/status side and byte-mux/strobe side of the RTC bus sequencer
interface rtc_bus_sequencer_if;
    logic       req;
    logic       rw;
    logic [7:0] wr_byte;
    logic [7:0] ad_in;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       err;
    logic       sel_addr;
    logic       sel_data;
    logic       ad_oe;
    logic       cs_n;
    logic       ale;
    logic       rd_n;
    logic       wr_n;

    modport master (
        output req, rw, wr_byte, ad_in,
        input  busy, done, rd_data, err, sel_addr, sel_data, ad_oe, cs_n, ale, rd_n, wr_n
    );

    modport slave (
        input  req, rw, wr_byte, ad_in,
        output busy, done, rd_data, err, sel_addr, sel_data, ad_oe, cs_n, ale, rd_n, wr_n
    );
endinterface

// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: one read/write transaction on the RTC multiplexed bus; RTC_RDBACK_EN adds write readback
module rtc_bus_sequencer #(
    parameter int T_PHASE = 4,
    parameter int CW      = 4
) (
    input logic clk,
    input logic reset,
    rtc_bus_sequencer_if.slave bus
);
`ifdef RTC_RDBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam logic [CW-1:0] LAST = CW'(T_PHASE - 1);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_AHOLD, S_WR, S_RD, S_END} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rw_q, rw_d;
    logic [7:0]      wb_q, wb_d;
    logic            pass_q, pass_d;
    logic            mism_q;
    logic            again, last, done_d;
    logic            busy_q, done_q, err_q, sel_addr_q, sel_data_q, ad_oe_q, cs_n_q, ale_q, rd_n_q, wr_n_q;
    logic [7:0]      rd_data_q;

    assign last  = cnt_q == LAST;
    // a write's first END is followed by the readback pass when readback is built in
    assign again = RB && !rw_q && !pass_q;

    // next state: phase counter runs 0..T_PHASE-1 in every non-idle state, then advances
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        wb_d    = wb_q;
        pass_d  = pass_q;
        if (state_q == S_IDLE) begin
            cnt_d  = '0;
            pass_d = 1'b0;
            if (bus.req) begin
                state_d = S_ADDR;
                rw_d    = bus.rw;
                wb_d    = bus.wr_byte;
            end
        end else if (last) begin
            cnt_d = '0;
            case (state_q)
                S_ADDR:  state_d = S_AHOLD;
                S_AHOLD: state_d = (rw_q || pass_q) ? S_RD : S_WR;
                S_WR:    state_d = S_END;
                S_RD:    state_d = S_END;
                default: begin
                    state_d = again ? S_ADDR : S_IDLE;
                    pass_d  = again;
                end
            endcase
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        done_d = state_d == S_END && cnt_d == LAST && !(RB && !rw_q && !pass_d);
    end

    // state, latched request and registered outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rw_q       <= 1'b0;
            wb_q       <= 8'h00;
            pass_q     <= 1'b0;
            mism_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_data_q  <= 8'h00;
            sel_addr_q <= 1'b0;
            sel_data_q <= 1'b0;
            ad_oe_q    <= 1'b0;
            cs_n_q     <= 1'b1;
            ale_q      <= 1'b0;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rw_q       <= rw_d;
            wb_q       <= wb_d;
            pass_q     <= pass_d;
            busy_q     <= state_d != S_IDLE;
            done_q     <= done_d;
            sel_addr_q <= state_d == S_ADDR || state_d == S_AHOLD;
            sel_data_q <= state_d == S_WR;
            ad_oe_q    <= state_d == S_ADDR || state_d == S_AHOLD || state_d == S_WR;
            cs_n_q     <= state_d == S_IDLE || state_d == S_END;
            ale_q      <= state_d == S_ADDR;
            rd_n_q     <= state_d != S_RD;
            wr_n_q     <= state_d != S_WR;
            if (state_q == S_RD && last) begin
                if (rw_q)
                    rd_data_q <= bus.ad_in;
                else
                    mism_q <= bus.ad_in != wb_q;
            end
            if (done_d && !rw_q)
                err_q <= RB && mism_q;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = RB ? err_q : 1'b0;
    assign bus.rd_data  = rd_data_q;
    assign bus.sel_addr = sel_addr_q;
    assign bus.sel_data = sel_data_q;
    assign bus.ad_oe    = ad_oe_q;
    assign bus.cs_n     = cs_n_q;
    assign bus.ale      = ale_q;
    assign bus.rd_n     = rd_n_q;
    assign bus.wr_n     = wr_n_q;
endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb_rtc_bus_sequencer: directed vector table plus hand sequences for the RTC bus sequencer (T_PHASE=2)
module tb_rtc_bus_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    rtc_bus_sequencer_if bus();

    rtc_bus_sequencer #(.T_PHASE(2), .CW(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // expected output bundle: {busy, done, sel_addr, sel_data, ad_oe, cs_n, ale, rd_n, wr_n}
    localparam logic [8:0] O_IDL = 9'b000001011;
    localparam logic [8:0] O_ADR = 9'b101010111;
    localparam logic [8:0] O_AHD = 9'b101010011;
    localparam logic [8:0] O_WRS = 9'b100110010;
    localparam logic [8:0] O_RDS = 9'b100000001;
    localparam logic [8:0] O_END = 9'b100001011;
    localparam logic [8:0] O_DON = 9'b110001011;

    typedef struct {
        logic       req;
        logic       rw;
        logic [7:0] wb;
        logic [7:0] ad;
        logic [8:0] exp;
        logic [7:0] rdd;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic req, input logic rw, input logic [7:0] wb,
                                input logic [7:0] ad, input logic [8:0] exp, input logic [7:0] rdd);
        vec_t v;
        v.req = req; v.rw = rw; v.wb = wb; v.ad = ad; v.exp = exp; v.rdd = rdd;
        return v;
    endfunction

    function automatic logic [8:0] outs();
        return {bus.busy, bus.done, bus.sel_addr, bus.sel_data, bus.ad_oe, bus.cs_n, bus.ale, bus.rd_n, bus.wr_n};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // bus-safety invariants on every cycle out of reset
    always @(negedge clk) begin
        if (!reset) begin
            total++;
            if ((bus.sel_addr && bus.sel_data) || (bus.ad_oe && !bus.rd_n) || (!bus.rd_n && !bus.wr_n)) begin
                bad++;
                $display("FAIL invariant at %0t: sel_addr=%b sel_data=%b ad_oe=%b rd_n=%b wr_n=%b",
                         $time, bus.sel_addr, bus.sel_data, bus.ad_oe, bus.rd_n, bus.wr_n);
            end
        end
    end

    task automatic rdback_write(input logic [7:0] ad, input logic expect_err);
        int dc;
        logic e;
        dc = -1;
        e = 1'bx;
        bus.req = 1'b1; bus.rw = 1'b0; bus.wr_byte = 8'hA5; bus.ad_in = ad;
        for (int c = 1; c <= 22; c++) begin
            step();
            bus.req = 1'b0;
            if (bus.done) begin
                dc = c;
                e = bus.err;
            end
        end
        chk("rdback_done_cycle", dc, 16);
        chk("rdback_err", {31'd0, e}, {31'd0, expect_err});
    endtask

    initial begin
        int dones;
        int wrlow;
        bus.req = 1'b0; bus.rw = 1'b0; bus.wr_byte = 8'h00; bus.ad_in = 8'h00;
        step();
        step();
        chk("reset_outs", outs(), O_IDL);
        chk("reset_rd_data", bus.rd_data, 8'h00);
        chk("reset_err", bus.err, 1'b0);
        reset = 1'b0;

`ifndef RTC_RDBACK_EN
        // write 5A with a stray read request in cycle 3 that must be ignored
        vq.push_back(mk(1, 0, 8'h5A, 8'h00, O_IDL, 8'h00));
        vq.push_back(mk(0, 0, 8'h00, 8'h00, O_ADR, 8'h00));
        vq.push_back(mk(0, 0, 8'h00, 8'h00, O_ADR, 8'h00));
        vq.push_back(mk(1, 1, 8'hFF, 8'h00, O_AHD, 8'h00));
        vq.push_back(mk(0, 0, 8'h00, 8'h00, O_AHD, 8'h00));
        vq.push_back(mk(0, 0, 8'h00, 8'h00, O_WRS, 8'h00));
        vq.push_back(mk(0, 0, 8'h00, 8'h00, O_WRS, 8'h00));
        vq.push_back(mk(0, 0, 8'h00, 8'h00, O_END, 8'h00));
        vq.push_back(mk(0, 0, 8'h00, 8'h00, O_DON, 8'h00));
        vq.push_back(mk(0, 0, 8'h00, 8'h00, O_IDL, 8'h00));
`endif
        // read with 37 on the pads
        vq.push_back(mk(1, 1, 8'h00, 8'h37, O_IDL, 8'h00));
        vq.push_back(mk(0, 0, 8'h00, 8'h37, O_ADR, 8'h00));
        vq.push_back(mk(0, 0, 8'h00, 8'h37, O_ADR, 8'h00));
        vq.push_back(mk(0, 0, 8'h00, 8'h37, O_AHD, 8'h00));
        vq.push_back(mk(0, 0, 8'h00, 8'h37, O_AHD, 8'h00));
        vq.push_back(mk(0, 0, 8'h00, 8'h37, O_RDS, 8'h00));
        vq.push_back(mk(0, 0, 8'h00, 8'h37, O_RDS, 8'h00));
        vq.push_back(mk(0, 0, 8'h00, 8'h00, O_END, 8'h37));
        vq.push_back(mk(0, 0, 8'h00, 8'h00, O_DON, 8'h37));
        vq.push_back(mk(0, 0, 8'h00, 8'h00, O_IDL, 8'h37));

        foreach (vq[i]) begin
            step();
            chk($sformatf("vec%0d_outs", i), outs(), vq[i].exp);
            chk($sformatf("vec%0d_rd_data", i), bus.rd_data, vq[i].rdd);
            bus.req = vq[i].req; bus.rw = vq[i].rw; bus.wr_byte = vq[i].wb; bus.ad_in = vq[i].ad;
        end
        step();
        bus.req = 1'b0;

        // reset asserted in cycle 5 of a write
        step();
        bus.req = 1'b1; bus.rw = 1'b0; bus.wr_byte = 8'h11;
        for (int c = 1; c <= 5; c++) begin
            step();
            bus.req = 1'b0;
        end
        chk("pre_reset_wr", outs(), O_WRS);
        reset = 1'b1;
        step();
        chk("midreset_outs", outs(), O_IDL);
        reset = 1'b0;
        step();
        bus.req = 1'b1; bus.rw = 1'b0; bus.wr_byte = 8'h22;
        dones = 0;
        wrlow = 0;
        for (int c = 1; c <= 30; c++) begin
            step();
            bus.req = 1'b0;
            dones += int'(bus.done);
            wrlow += int'(!bus.wr_n);
        end
        chk("post_reset_dones", dones, 1);
        chk("post_reset_wrlow", wrlow, 2);
        chk("post_reset_idle", outs(), O_IDL);

`ifdef RTC_RDBACK_EN
        step();
        rdback_write(8'hA4, 1'b1);
        rdback_write(8'hA5, 1'b0);
`else
        chk("err_tied_low", bus.err, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
